// File: rtl/ssd_pkg.sv
// Shared definitions for the score feed: segment codes, FSM states and a
// single-digit BCD adder used by the score accumulator.
package ssd_pkg;

    // Segment bit order {a,b,c,d,e,f,g,dp}, active-low, dp always off.
    localparam logic [7:0] SEG_0     = 8'h03;
    localparam logic [7:0] SEG_1     = 8'h9F;
    localparam logic [7:0] SEG_2     = 8'h25;
    localparam logic [7:0] SEG_3     = 8'h0D;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h49;
    localparam logic [7:0] SEG_6     = 8'h41;
    localparam logic [7:0] SEG_7     = 8'h1F;
    localparam logic [7:0] SEG_8     = 8'h01;
    localparam logic [7:0] SEG_9     = 8'h09;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic {
        S_PLAY   = 1'b0,
        S_FROZEN = 1'b1
    } state_e;

    typedef struct packed {
        logic       carry;
        logic [3:0] digit;
    } digit_sum_t;

    // Adds a small increment (0..3) to one BCD digit and reports the decimal carry.
    function automatic digit_sum_t bcd_digit_add(input logic [3:0] a, input logic [2:0] b);
        digit_sum_t res;
        logic [4:0] s;
        logic [4:0] t;
        s = {1'b0, a} + {2'b00, b};
        t = s - 5'd10;
        if (s > 5'd9) begin
            res.carry = 1'b1;
            res.digit = t[3:0];
        end else begin
            res.carry = 1'b0;
            res.digit = s[3:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_to_ssd.sv
// One BCD digit to an active-low seven-segment pattern; blank_i forces all
// segments off.
module bcd_to_ssd
    import ssd_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    // NOTE: every output of an always_comb gets a default first so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (bcd_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/ssd_score_feed.sv
// Saturating 4-digit BCD score with freeze/blink at game over, leading-zero
// blanking, registered segment patterns and the display scan index.
module ssd_score_feed
    import ssd_pkg::*;
#(
    parameter int SCAN_BITS  = 17,
    parameter int BLINK_BITS = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       add_en,
    input  logic [1:0] add_val,
    input  logic       clear,
    input  logic       game_over,
    output logic [7:0] four,
    output logic [7:0] three,
    output logic [7:0] two,
    output logic [7:0] one,
    output logic [1:0] clk_scan,
    output logic       frozen
);

    state_e                state_q, state_d;
    logic [3:0][3:0]       score_q, score_d;
    logic [3:0][3:0]       score_sum;
    logic [SCAN_BITS-1:0]  scan_q;
    logic [BLINK_BITS-1:0] blink_q, blink_d;
    logic [3:0][7:0]       seg_q, seg_d;
    logic [3:0][7:0]       seg_pat;
    logic [3:0]            blank;
    logic                  blink_off;

    // Ripple the increment through d0..d3; a carry out of d3 saturates at 9999.
    always_comb begin
        digit_sum_t r;
        logic [2:0] inc;
        score_sum = score_q;
        inc       = {1'b0, add_val};
        r         = '0;
        for (int i = 0; i < 4; i++) begin
            r            = bcd_digit_add(score_q[i], inc);
            score_sum[i] = r.digit;
            inc          = {2'b00, r.carry};
        end
        if (inc != 3'd0) begin
            score_sum = {4'd9, 4'd9, 4'd9, 4'd9};
        end
    end

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        blink_d = '0;
        if (clear) begin
            state_d = S_PLAY;
            score_d = '0;
        end else if (state_q == S_FROZEN) begin
            blink_d = blink_q + BLINK_BITS'(1);
        end else if (game_over) begin
            state_d = S_FROZEN;
        end else if (add_en) begin
            score_d = score_sum;
        end
    end

    assign blank[3] = (score_q[3] == 4'd0);
    assign blank[2] = blank[3] && (score_q[2] == 4'd0);
    assign blank[1] = blank[2] && (score_q[1] == 4'd0);
    assign blank[0] = 1'b0;

    for (genvar g = 0; g < 4; g++) begin : g_digit
        bcd_to_ssd u_bcd_to_ssd (
            .bcd_i   (score_q[g]),
            .blank_i (blank[g]),
            .seg_o   (seg_pat[g])
        );
    end

    assign blink_off = (state_q == S_FROZEN) && blink_q[BLINK_BITS-1];
    assign seg_d     = blink_off ? {4{SEG_BLANK}} : seg_pat;

    // NOTE: registers are written only with non-blocking assignments so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_PLAY;
            score_q <= '0;
            scan_q  <= '0;
            blink_q <= '0;
            seg_q   <= {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_0};
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            scan_q  <= scan_q + SCAN_BITS'(1);
            blink_q <= blink_d;
            seg_q   <= seg_d;
        end
    end

    assign four     = seg_q[3];
    assign three    = seg_q[2];
    assign two      = seg_q[1];
    assign one      = seg_q[0];
    assign clk_scan = scan_q[SCAN_BITS-1:SCAN_BITS-2];
    assign frozen   = (state_q == S_FROZEN);

endmodule

// File: tb/tb_ssd_score_feed.sv
// Directed bench for ssd_score_feed with short scan and blink counters so scan
// stepping and blink phases are visible within a few cycles.
module tb_ssd_score_feed;

    localparam int SCAN_BITS  = 4;
    localparam int BLINK_BITS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       add_en = 1'b0;
    logic [1:0] add_val = 2'd0;
    logic       clear = 1'b0;
    logic       game_over = 1'b0;
    logic [7:0] four, three, two, one;
    logic [1:0] clk_scan;
    logic       frozen;

    int errors = 0;
    int checks = 0;

    ssd_score_feed #(
        .SCAN_BITS  (SCAN_BITS),
        .BLINK_BITS (BLINK_BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .add_en    (add_en),
        .add_val   (add_val),
        .clear     (clear),
        .game_over (game_over),
        .four      (four),
        .three     (three),
        .two       (two),
        .one       (one),
        .clk_scan  (clk_scan),
        .frozen    (frozen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [1:0] v);
        add_en  = 1'b1;
        add_val = v;
        step();
        add_en  = 1'b0;
        add_val = 2'd0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
    endtask

    task automatic check_digits(input string tag, input logic [7:0] e4, input logic [7:0] e3,
                                input logic [7:0] e2, input logic [7:0] e1);
        check({tag, ".four"},  four,  e4);
        check({tag, ".three"}, three, e3);
        check({tag, ".two"},   two,   e2);
        check({tag, ".one"},   one,   e1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values and scan stepping.
        step();
        rst = 1'b0;
        check_digits("reset", 8'hFF, 8'hFF, 8'hFF, 8'h03);
        check("reset.frozen", frozen, 1'b0);
        check("scan.k0", clk_scan, 2'd0);
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k % 4 == 0) check($sformatf("scan.k%0d", k), clk_scan, 32'((k / 4) % 4));
        end

        // Two-cycle latency from add to pattern.
        add(2'd1);
        check("latency.edgeN", one, 8'h03);
        step();
        check("latency.edgeN1", one, 8'h9F);

        // Carry ripple: 0 -> 111 -> 112.
        do_clear();
        for (int i = 0; i < 37; i++) add(2'd3);
        add(2'd1);
        step();
        check_digits("ripple112", 8'hFF, 8'h9F, 8'h9F, 8'h25);

        // Leading-zero blanking keeps interior zeros: 0105.
        do_clear();
        for (int i = 0; i < 35; i++) add(2'd3);
        step();
        check_digits("lz0105", 8'hFF, 8'h9F, 8'h03, 8'h49);

        // Saturation: 9998 + 3 = 9999, and further adds hold 9999.
        do_clear();
        for (int i = 0; i < 3332; i++) add(2'd3);
        add(2'd2);
        step();
        check_digits("pre9998", 8'h09, 8'h09, 8'h09, 8'h01);
        add(2'd3);
        step();
        check_digits("sat9999", 8'h09, 8'h09, 8'h09, 8'h09);
        add(2'd1);
        step();
        check_digits("sat_hold", 8'h09, 8'h09, 8'h09, 8'h09);

        // clear beats add_en in the same cycle.
        clear   = 1'b1;
        add_en  = 1'b1;
        add_val = 2'd3;
        step();
        clear   = 1'b0;
        add_en  = 1'b0;
        step();
        check_digits("clr_add", 8'hFF, 8'hFF, 8'hFF, 8'h03);

        // game_over beats add_en; then blink with add_en and game_over held.
        add(2'd2);
        game_over = 1'b1;
        add_en    = 1'b1;
        add_val   = 2'd3;
        step();
        check("go.frozen", frozen, 1'b1);
        for (int m = 1; m <= 12; m++) begin
            step();
            check($sformatf("blink.m%0d", m), one, (((m - 1) / 4) % 2 == 1) ? 8'hFF : 8'h25);
        end
        check("blink.four", four, 8'hFF);
        check("blink.still_frozen", frozen, 1'b1);
        game_over = 1'b0;
        add_en    = 1'b0;
        add_val   = 2'd0;
        do_clear();
        check("unfreeze.frozen", frozen, 1'b0);
        check_digits("unfreeze", 8'hFF, 8'hFF, 8'hFF, 8'h03);

        // Reset during the blank phase of a blink.
        add(2'd3);
        game_over = 1'b1;
        step();
        game_over = 1'b0;
        for (int m = 1; m <= 5; m++) step();
        check("midblink.blank", one, 8'hFF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_digits("midrst", 8'hFF, 8'hFF, 8'hFF, 8'h03);
        check("midrst.frozen", frozen, 1'b0);
        check("midrst.scan", clk_scan, 2'd0);
        step();
        check("midrst.score", one, 8'h03);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
